// File: rtl/tug_pkg.sv
// -----------------------------------------------------------------------------
// tug_pkg
// Shared definitions for the tug-of-war front end.
//   key_state_t  : per-channel debounce FSM state
//   SIM_DEBOUNCE : debounce length used for fast simulation builds
//   HW_DEBOUNCE  : debounce length for the board (10 ms at 50 MHz)
//   cnt_width()  : width of a counter able to hold 0..n
// -----------------------------------------------------------------------------
package tug_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    PRESSED   = 2'd2,
    RELEASING = 2'd3
  } key_state_t;

  localparam int SIM_DEBOUNCE = 16;
  localparam int HW_DEBOUNCE  = 500000;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/tug_key_conditioner_if.sv
// -----------------------------------------------------------------------------
// tug_key_conditioner_if
// Bundles the raw player buttons and the conditioned press pulses.
//   key_l_n / key_r_n : raw active-low buttons, asynchronous to clk
//   L / R             : conditioned press pulses, synchronous to clk
// Handshake: there is no valid/ready pair. L and R are fire-and-forget strobes;
// each is high for exactly one clk cycle per accepted press, the consumer must
// take it in that cycle, and no backpressure exists.
// Modports:
//   master : the button side (drives keys, observes pulses)
//   slave  : the conditioner side (observes keys, drives pulses)
// -----------------------------------------------------------------------------
interface tug_key_conditioner_if;

  logic key_l_n;
  logic key_r_n;
  logic L;
  logic R;

  modport master (
    output key_l_n,
    output key_r_n,
    input  L,
    input  R
  );

  modport slave (
    input  key_l_n,
    input  key_r_n,
    output L,
    output R
  );

endinterface

// File: rtl/key_channel.sv
// -----------------------------------------------------------------------------
// key_channel
// One button channel: 2-flop synchronizer, debounce counter and a 4-state FSM
// that emits a single registered pulse per accepted press.
// Parameters:
//   DEBOUNCE_CYCLES : stable samples needed to accept a press or release (>=2)
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   key_n  in   raw active-low button, asynchronous to clk
//   press  out  one-cycle registered press pulse
// -----------------------------------------------------------------------------
module key_channel
  import tug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  key_state_t      state_q, state_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic            press_q, press_d;
  logic            s;

  always_comb begin
    sync1_d = key_n;
    sync2_d = sync1_q;
    // Synchronized level, inverted so 1 means the button is held down.
    s       = ~sync2_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    press_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = ARMING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      ARMING: begin
        if (!s) begin
          // Bounce during the press: start over.
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          press_d = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      RELEASING: begin
        if (s) begin
          // Release bounce: back to held, and deliberately no new pulse.
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Synchronizer flops reset to the released level so a key held through
  // reset is seen as a fresh press once reset goes away.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/tug_key_conditioner.sv
// -----------------------------------------------------------------------------
// tug_key_conditioner
// Front end of the tug-of-war game: turns the two raw player buttons into
// single-cycle L/R press pulses for the playfield light cells. Two independent
// key_channel instances; this level is wiring only and does no arbitration, so
// L and R may be high in the same cycle.
// Parameters:
//   DEBOUNCE_CYCLES : stable samples needed per press/release (>=2);
//                     the board top overrides this with HW_DEBOUNCE
// Ports:
//   clk      in   system clock (50 MHz)
//   reset    in   asynchronous active-high reset
//   key_l_n  in   raw left button, active low, asynchronous
//   key_r_n  in   raw right button, active low, asynchronous
//   L        out  left press pulse, one cycle per accepted press
//   R        out  right press pulse, one cycle per accepted press
// -----------------------------------------------------------------------------
module tug_key_conditioner
  import tug_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SIM_DEBOUNCE
) (
  input  logic clk,
  input  logic reset,
  input  logic key_l_n,
  input  logic key_r_n,
  output logic L,
  output logic R
);

  key_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_left (
    .clk   (clk),
    .reset (reset),
    .key_n (key_l_n),
    .press (L)
  );

  key_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_right (
    .clk   (clk),
    .reset (reset),
    .key_n (key_r_n),
    .press (R)
  );

endmodule
